// File: rtl/dense_acc_pkg.sv
//----------------------------------------------------------------------------
// dense_acc_pkg
// Shared types and constant helpers for the dense-layer accumulate/quantise
// stage: state encoding, output range limits, rounding constant and the
// accumulator width legality check.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package dense_acc_pkg;

  // Controller states: accumulate beats, round/saturate, hold result
  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_RND = 2'd1,
    ST_OUT = 2'd2
  } state_e;

  // Largest value representable in a signed field of width w
  function automatic longint out_max_f(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Smallest value representable in a signed field of width w
  function automatic longint out_min_f(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Half an output LSB at accumulator scale (round half toward +inf)
  function automatic longint rnd_const_f(input int sh);
    return longint'(1) <<< (sh - 1);
  endfunction

  // The accumulator must hold a full vector of products plus bias without wrap
  function automatic bit acc_width_ok_f(input int accw, input int prodw,
                                        input int nterms);
    return accw >= (prodw + $clog2(nterms) + 1);
  endfunction

endpackage : dense_acc_pkg

`default_nettype wire

// File: rtl/dense_acc_round_sat.sv
//----------------------------------------------------------------------------
// dense_acc_round_sat
// Combinational round (half toward +inf), optional ReLU and saturation of the
// accumulator into the signed output format.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module dense_acc_round_sat
  import dense_acc_pkg::*;
#(
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int RELU       = 0
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 sat_o
);

  // One guard bit so adding the rounding constant can never wrap
  localparam logic signed [ACC_WIDTH:0] C_RND = (ACC_WIDTH+1)'(rnd_const_f(FRAC_SHIFT));
  localparam logic signed [ACC_WIDTH:0] C_MAX = (ACC_WIDTH+1)'(out_max_f(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH:0] C_MIN = (ACC_WIDTH+1)'(out_min_f(OUT_WIDTH));

  logic signed [ACC_WIDTH:0] w_sum;
  logic signed [ACC_WIDTH:0] w_r;

  assign w_sum = $signed({acc_i[ACC_WIDTH-1], acc_i}) + C_RND;
  assign w_r   = w_sum >>> FRAC_SHIFT;

  // Select ReLU zero, clip limit or the in-range rounded value
  always_comb begin
    data_o = w_r[OUT_WIDTH-1:0];
    sat_o  = 1'b0;
    if ((RELU != 0) && w_r[ACC_WIDTH]) begin
      data_o = '0;
      sat_o  = 1'b0;
    end else if (w_r > C_MAX) begin
      data_o = C_MAX[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end else if (w_r < C_MIN) begin
      data_o = C_MIN[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule : dense_acc_round_sat

`default_nettype wire

// File: rtl/dense_acc_quant.sv
//----------------------------------------------------------------------------
// dense_acc_quant
// Accumulates N_TERMS signed products plus a bias, then rounds, optionally
// applies ReLU and saturates to the output format. One result per vector is
// offered on a valid/ready port.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module dense_acc_quant
  import dense_acc_pkg::*;
#(
  parameter int PROD_WIDTH = 24,
  parameter int BIAS_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int N_TERMS    = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int RELU       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  prod_valid,
  input  logic [PROD_WIDTH-1:0] prod,
  input  logic                  prod_last,
  input  logic [BIAS_WIDTH-1:0] bias,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic                  err_len
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(N_TERMS - 1);

  // Reject parameter sets where the accumulator could silently wrap
  if (!acc_width_ok_f(ACC_WIDTH, PROD_WIDTH, N_TERMS)) begin : g_acc_width_chk
    $error("dense_acc_quant: ACC_WIDTH too small for PROD_WIDTH and N_TERMS");
  end
  if (FRAC_SHIFT < 1) begin : g_frac_shift_chk
    $error("dense_acc_quant: FRAC_SHIFT must be at least 1");
  end

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 sat_q, sat_d;
  logic                 err_q, err_d;

  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0] w_bias_ext;
  logic [OUT_WIDTH-1:0] w_rs_data;
  logic                 w_rs_sat;
  logic                 w_nth_beat;

  assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
  assign w_bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
  assign w_nth_beat = (cnt_q == C_LAST_IDX);

  dense_acc_round_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT),
    .OUT_WIDTH  (OUT_WIDTH),
    .RELU       (RELU)
  ) u_round_sat (
    .acc_i  (acc_q),
    .data_o (w_rs_data),
    .sat_o  (w_rs_sat)
  );

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sat   = sat_q;
  assign err_len   = err_q;

  // Next-state logic: accumulate beats, capture the quantised result, handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    sat_d   = sat_q;
    err_d   = err_q;
    case (state_q)
      ST_ACC: begin
        if (ce && prod_valid) begin
          acc_d = ((cnt_q == '0) ? w_bias_ext : acc_q) + w_prod_ext;
          cnt_d = cnt_q + CNT_W'(1);
          // Early last or a missing last on the final beat both flag a length error
          if (prod_last != w_nth_beat) begin
            err_d = 1'b1;
          end
          if (prod_last || w_nth_beat) begin
            state_d = ST_RND;
          end
        end
      end
      ST_RND: begin
        if (ce) begin
          data_d  = w_rs_data;
          sat_d   = w_rs_sat;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial sum or pending result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

endmodule : dense_acc_quant

`default_nettype wire

// File: tb/tb_dense_acc_quant.sv
//----------------------------------------------------------------------------
// tb_dense_acc_quant
// Directed bench for dense_acc_quant with N_TERMS=4, FRAC_SHIFT=8,
// OUT_WIDTH=16. Two instances share stimulus: one without ReLU, one with.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_dense_acc_quant;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        prod_valid = 1'b0;
  logic [23:0] prod = '0;
  logic        prod_last = 1'b0;
  logic [15:0] bias = '0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, out_sat0, err_len0;
  logic [15:0] out_data0;
  logic        in_ready1, out_valid1, out_sat1, err_len1;
  logic [15:0] out_data1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dense_acc_quant #(.N_TERMS(4), .RELU(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .prod_valid(prod_valid), .prod(prod),
    .prod_last(prod_last), .bias(bias), .in_ready(in_ready0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0), .err_len(err_len0)
  );

  dense_acc_quant #(.N_TERMS(4), .RELU(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .prod_valid(prod_valid), .prod(prod),
    .prod_last(prod_last), .bias(bias), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1), .err_len(err_len1)
  );

  typedef struct {
    string            name;
    logic [15:0]      b;
    logic [3:0][23:0] p;
    int               n;
    bit               use_last;
    int               exp0;
    bit               sat0;
    int               exp1;
    bit               sat1;
    bit               err;
  } vec_t;

  function automatic vec_t mk(input string nm, input int b, input int p0, input int p1,
                              input int p2, input int p3, input int n, input bit ul,
                              input int e0, input bit s0, input int e1, input bit s1,
                              input bit er);
    vec_t v;
    v.name = nm; v.b = 16'(b);
    v.p = {24'(p3), 24'(p2), 24'(p1), 24'(p0)};
    v.n = n; v.use_last = ul;
    v.exp0 = e0; v.sat0 = s0; v.exp1 = e1; v.sat1 = s1; v.err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [23:0] p, input logic last, input logic [15:0] b);
    prod_valid = 1'b1; prod = p; prod_last = last; bias = b;
    @(posedge clk); #1;
    prod_valid = 1'b0; prod_last = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_valid_low", 32'(out_valid0), 0);
    chk("hs_in_ready", 32'(in_ready0), 1);
  endtask

  // Drive one vector, check latency and both instances' results
  task automatic run_vec(input vec_t v, input bit do_hs);
    for (int i = 0; i < v.n; i++) begin
      send_beat(v.p[i], v.use_last && (i == v.n - 1), v.b);
    end
    chk({v.name, "_lat_early"}, 32'(out_valid0), 0);
    @(posedge clk); #1;
    chk({v.name, "_lat"}, 32'(out_valid0), 1);
    chk({v.name, "_data"}, $signed(out_data0), v.exp0);
    chk({v.name, "_sat"}, 32'(out_sat0), 32'(v.sat0));
    chk({v.name, "_relu_data"}, $signed(out_data1), v.exp1);
    chk({v.name, "_relu_sat"}, 32'(out_sat1), 32'(v.sat1));
    chk({v.name, "_err"}, 32'(err_len0), 32'(v.err));
    if (do_hs) handshake();
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid0), 0);
    chk("rst_in_ready", 32'(in_ready0), 1);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t tbl[7];
  vec_t basic;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    basic  = mk("basic", 256, 256, 512, -256, 768, 4, 1, 6, 0, 6, 0, 0);
    tbl[0] = basic;
    tbl[1] = mk("sat_pos", 0, 8388607, 8388607, 8388607, 8388607, 4, 1, 32767, 1, 32767, 1, 0);
    tbl[2] = mk("sat_neg", 0, -8388608, -8388608, -8388608, -8388608, 4, 1, -32768, 1, 0, 0, 0);
    tbl[3] = mk("neg1000", 0, -1000, -1000, -1000, -1000, 4, 1, -16, 0, 0, 0, 0);
    tbl[4] = mk("tie_m128", 0, -32, -32, -32, -32, 4, 1, 0, 0, 0, 0, 0);
    tbl[5] = mk("m129", 0, -32, -32, -32, -33, 4, 1, -1, 0, 0, 0, 0);
    tbl[6] = mk("tie_p128", 128, 0, 0, 0, 0, 4, 1, 1, 0, 1, 0, 0);

    // Reset values while reset is held
    #3;
    chk("rst_out_valid", 32'(out_valid0), 0);
    chk("rst_out_data", $signed(out_data0), 0);
    chk("rst_out_sat", 32'(out_sat0), 0);
    chk("rst_err_len", 32'(err_len0), 0);
    chk("rst_in_ready", 32'(in_ready0), 1);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], 1'b1);

    // Backpressure: beats offered while the result is held must be ignored
    run_vec(basic, 1'b0);
    for (int c = 0; c < 5; c++) begin
      prod_valid = 1'b1; prod = 24'd1000; prod_last = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid0), 1);
      chk("bp_data", $signed(out_data0), 6);
      chk("bp_in_ready", 32'(in_ready0), 0);
    end
    prod_valid = 1'b0; prod_last = 1'b0;
    handshake();
    run_vec(basic, 1'b1);

    // Clock enable low freezes accumulation and the rounding step
    send_beat(24'd256, 1'b0, 16'd256);
    ce = 1'b0; prod_valid = 1'b1; prod = 24'd5000;
    @(posedge clk); @(posedge clk); #1;
    prod_valid = 1'b0; ce = 1'b1;
    send_beat(24'd512, 1'b0, 16'd0);
    send_beat(-24'sd256, 1'b0, 16'd0);
    send_beat(24'd768, 1'b1, 16'd0);
    ce = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("ce_rnd_hold", 32'(out_valid0), 0);
    ce = 1'b1;
    @(posedge clk); #1;
    chk("ce_valid", 32'(out_valid0), 1);
    chk("ce_data", $signed(out_data0), 6);
    handshake();

    // Early prod_last: result from three beats, sticky error
    run_vec(mk("short", 0, 256, 256, 256, 0, 3, 1, 3, 0, 3, 0, 1), 1'b1);
    run_vec(mk("sticky", 256, 256, 512, -256, 768, 4, 1, 6, 0, 6, 0, 1), 1'b1);

    // Missing prod_last after reset
    do_reset();
    chk("rst_err_clear", 32'(err_len0), 0);
    run_vec(mk("nolast", 0, 256, 256, 256, 256, 4, 0, 4, 0, 4, 0, 1), 1'b1);

    // Reset mid-vector, then a clean vector
    do_reset();
    send_beat(24'd256, 1'b0, 16'd256);
    send_beat(24'd1000, 1'b0, 16'd0);
    do_reset();
    run_vec(basic, 1'b1);

    // Reset while a result is pending
    run_vec(basic, 1'b0);
    do_reset();
    chk("rst_pend_data", $signed(out_data0), 0);
    run_vec(basic, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dense_acc_quant

`default_nettype wire
